// File: rtl/uart_baudgen_frac.sv
// Fractional-N baud tick generator. Produces one-cycle oversample, bit and
// mid-bit ticks from a runtime-loadable integer+fraction clock divisor.
module uart_baudgen_frac #(
  parameter int  SystemClockFreq = 50_000_000,
  parameter int  BaudRate        = 9600,
  parameter int  OverSample      = 16,
  parameter int  IntWidth        = 16,
  parameter int  FracWidth       = 8,
  localparam int IdxW            = $clog2(OverSample)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_sync,
  input  logic                 i_div_load,
  input  logic [IntWidth-1:0]  i_div_int,
  input  logic [FracWidth-1:0] i_div_frac,
  output logic                 o_os_tick,
  output logic                 o_bit_tick,
  output logic                 o_mid_tick,
  output logic [IdxW-1:0]      o_os_idx,
  output logic                 o_cfg_err
);

  localparam int TickRate = BaudRate * OverSample;
  localparam logic [IntWidth-1:0]  DefInt  = IntWidth'(SystemClockFreq / TickRate);
  localparam logic [FracWidth-1:0] DefFrac =
    FracWidth'((longint'(SystemClockFreq % TickRate) << FracWidth) / TickRate);
  localparam int CntW = IntWidth + 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(OverSample - 1);
  localparam logic [IdxW-1:0] IdxMid  = IdxW'(OverSample / 2);

  logic [IntWidth-1:0]  div_int_q, div_int_d;
  logic [FracWidth-1:0] div_frac_q, div_frac_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [FracWidth-1:0] acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      p_q, p_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 os_tick_q, os_tick_d;
  logic                 bit_tick_q, bit_tick_d;
  logic                 mid_tick_q, mid_tick_d;

  // A same-edge valid load feeds straight into any interval start on that edge.
  logic                 load_ok;
  logic [IntWidth-1:0]  int_eff;
  logic [FracWidth-1:0] frac_eff;
  logic [FracWidth-1:0] acc_start;
  logic [FracWidth:0]   sum;
  logic [CntW-1:0]      p_new;
  logic [IdxW-1:0]      idx_inc;

  assign load_ok   = i_div_load && (i_div_int >= IntWidth'(2));
  assign int_eff   = load_ok ? i_div_int  : div_int_q;
  assign frac_eff  = load_ok ? i_div_frac : div_frac_q;
  // A sync restarts the accumulator from zero before the fresh interval is sized.
  assign acc_start = i_sync ? '0 : acc_q;
  assign sum       = {1'b0, acc_start} + {1'b0, frac_eff};
  assign p_new     = {1'b0, int_eff} + {{IntWidth{1'b0}}, sum[FracWidth]};
  assign idx_inc   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;

  // Next-state: divisor load, sync restart, interval counting and tick decode.
  always_comb begin
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    cfg_err_d  = cfg_err_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    idx_d      = idx_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;

    if (i_div_load) begin
      if (load_ok) begin
        div_int_d  = i_div_int;
        div_frac_d = i_div_frac;
        cfg_err_d  = 1'b0;
      end else begin
        cfg_err_d  = 1'b1;
      end
    end

    if (i_sync) begin
      cnt_d = '0;
      idx_d = '0;
      acc_d = sum[FracWidth-1:0];
      p_d   = p_new;
    end else if (i_en) begin
      if (cnt_q == p_q - 1'b1) begin
        cnt_d      = '0;
        acc_d      = sum[FracWidth-1:0];
        p_d        = p_new;
        idx_d      = idx_inc;
        os_tick_d  = 1'b1;
        bit_tick_d = (idx_inc == '0);
        mid_tick_d = (idx_inc == IdxMid);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers. Reset leaves the block just past an interval start with
  // acc=0: the first interval is DefInt long (0+DefFrac cannot carry) and the
  // accumulator already holds DefFrac.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_int_q  <= DefInt;
      div_frac_q <= DefFrac;
      cfg_err_q  <= 1'b0;
      acc_q      <= DefFrac;
      cnt_q      <= '0;
      p_q        <= {1'b0, DefInt};
      idx_q      <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      cfg_err_q  <= cfg_err_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      idx_q      <= idx_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign o_os_tick  = os_tick_q;
  assign o_bit_tick = bit_tick_q;
  assign o_mid_tick = mid_tick_q;
  assign o_os_idx   = idx_q;
  assign o_cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Scoreboard bench for uart_baudgen_frac: stimulus pushes hand-computed tick
// expectations (cycle, index, bit/mid flags); a monitor pops one per os tick.
module tb_uart_baudgen_frac;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_sync = 1'b0;
  logic        i_div_load = 1'b0;
  logic [15:0] i_div_int = '0;
  logic [7:0]  i_div_frac = '0;
  logic        o_os_tick, o_bit_tick, o_mid_tick, o_cfg_err;
  logic [3:0]  o_os_idx;

  uart_baudgen_frac dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_sync(i_sync),
    .i_div_load(i_div_load), .i_div_int(i_div_int), .i_div_frac(i_div_frac),
    .o_os_tick(o_os_tick), .o_bit_tick(o_bit_tick), .o_mid_tick(o_mid_tick),
    .o_os_idx(o_os_idx), .o_cfg_err(o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    bit chk_t;
    int idx;
    bit bt;
    bit mt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_tick  = 0;

  // Expected tick: bit tick on index 0, mid tick on index 8 (OverSample=16).
  task automatic push(input int t, input bit chk_t, input int idx);
    exp_t e;
    e.t = t; e.chk_t = chk_t; e.idx = idx;
    e.bt = (idx == 0); e.mt = (idx == 8);
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge i_clk);
  endtask

  // Wait (bounded) until every expected tick was seen, then stop the generator.
  task automatic drain(input int bound, input string nm);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge i_clk);
      n++;
    end
    i_en = 1'b0;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d ticks outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: one scoreboard pop per observed os tick.
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_rst_n) begin
      if (o_os_tick) begin
        n_tick++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tick: at cyc %0d idx %0d, expected no tick", cyc, o_os_idx);
        end else begin
          e = sb.pop_front();
          if ((e.chk_t && cyc != e.t) || int'(o_os_idx) != e.idx ||
              o_bit_tick != e.bt || o_mid_tick != e.mt) begin
            n_fail++;
            $display("FAIL tick%0d: got cyc=%0d idx=%0d bit=%0b mid=%0b, expected cyc=%0d(chk=%0b) idx=%0d bit=%0b mid=%0b",
                     n_tick, cyc, o_os_idx, o_bit_tick, o_mid_tick, e.t, e.chk_t, e.idx, e.bt, e.mt);
          end
        end
      end else if (o_bit_tick || o_mid_tick) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_flag: got bit=%0b mid=%0b without os tick, expected 0", o_bit_tick, o_mid_tick);
      end
    end
  end

  initial begin
    int b;

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_os_tick", o_os_tick, 0);
    chk("rst_bit_tick", o_bit_tick, 0);
    chk("rst_mid_tick", o_mid_tick, 0);
    chk("rst_os_idx", o_os_idx, 0);
    chk("rst_cfg_err", o_cfg_err, 0);

    // Default 325+133/256: 256 ticks span 83333 cycles
    b = cyc;
    i_rst_n = 1'b1;
    i_en    = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      if (k == 1)        push(b + 325, 1, k % 16);
      else if (k == 2)   push(b + 651, 1, k % 16);
      else if (k == 3)   push(b + 976, 1, k % 16);
      else if (k == 256) push(b + 83333, 1, k % 16);
      else               push(0, 0, k % 16);
    end
    drain(90000, "default");
    chk("default_cfg_err", o_cfg_err, 0);

    // int=4 frac=0, then sync: tick every 4, bit every 64, mid 32 after bit
    i_div_load = 1'b1; i_div_int = 16'd4; i_div_frac = 8'd0;
    @(negedge i_clk);
    i_div_load = 1'b0;
    chk("load4_cfg_err", o_cfg_err, 0);
    b = cyc;
    i_sync = 1'b1; i_en = 1'b1;
    for (int k = 1; k <= 32; k++) push(b + 1 + 4 * k, 1, k % 16);
    @(negedge i_clk);
    i_sync = 1'b0;
    drain(200, "int4");

    // int=4 frac=128 loaded together with sync: lengths 4,5,4,5,...
    b = cyc;
    i_div_load = 1'b1; i_div_int = 16'd4; i_div_frac = 8'd128;
    i_sync = 1'b1; i_en = 1'b1;
    push(b + 1 + 4, 1, 1);  push(b + 1 + 9, 1, 2);
    push(b + 1 + 13, 1, 3); push(b + 1 + 18, 1, 4);
    push(b + 1 + 22, 1, 5); push(b + 1 + 27, 1, 6);
    push(b + 1 + 31, 1, 7); push(b + 1 + 36, 1, 8);
    @(negedge i_clk);
    i_div_load = 1'b0; i_sync = 1'b0;
    drain(100, "frac128");

    // Sync 2 cycles after a tick: old due point suppressed, next tick idx 1
    b = cyc;
    i_div_load = 1'b1; i_div_int = 16'd4; i_div_frac = 8'd0;
    i_sync = 1'b1; i_en = 1'b1;
    push(b + 5, 1, 1);
    @(negedge i_clk);
    i_div_load = 1'b0; i_sync = 1'b0;
    at_cyc(b + 6);
    i_sync = 1'b1;
    push(b + 11, 1, 1);
    @(negedge i_clk);
    i_sync = 1'b0;
    drain(50, "resync");

    // Invalid load keeps spacing; valid load int=6 applies next interval;
    // 10 disabled cycles mid-interval resume with the remaining count
    b = cyc;
    i_div_load = 1'b1; i_div_int = 16'd4; i_div_frac = 8'd0;
    i_sync = 1'b1; i_en = 1'b1;
    push(b + 5, 1, 1);  push(b + 9, 1, 2);
    push(b + 15, 1, 3); push(b + 21, 1, 4);
    push(b + 37, 1, 5); push(b + 43, 1, 6);
    @(negedge i_clk);
    i_sync = 1'b0; i_div_int = 16'd1;
    @(negedge i_clk);
    i_div_load = 1'b0;
    chk("bad_load_cfg_err", o_cfg_err, 1);
    at_cyc(b + 6);
    i_div_load = 1'b1; i_div_int = 16'd6;
    @(negedge i_clk);
    i_div_load = 1'b0;
    chk("good_load_cfg_err", o_cfg_err, 0);
    at_cyc(b + 23);
    i_en = 1'b0;
    at_cyc(b + 33);
    i_en = 1'b1;
    drain(100, "int6_hold");

    // Async reset mid-interval, then default timing from idx 0
    i_en = 1'b1;
    i_div_load = 1'b1; i_div_int = 16'd0;
    @(negedge i_clk);
    i_div_load = 1'b0;
    @(negedge i_clk);
    chk("pre_rst_cfg_err", o_cfg_err, 1);
    chk("pre_rst_os_idx", o_os_idx, 6);
    #1 i_rst_n = 1'b0;
    #1;
    chk("async_rst_os_idx", o_os_idx, 0);
    chk("async_rst_cfg_err", o_cfg_err, 0);
    chk("async_rst_os_tick", o_os_tick, 0);
    repeat (3) @(negedge i_clk);
    b = cyc;
    i_rst_n = 1'b1;
    push(b + 325, 1, 1);
    push(b + 651, 1, 2);
    drain(800, "post_rst");
    chk("post_rst_cfg_err", o_cfg_err, 0);

    repeat (3) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_baudgen_frac.md
# uart_baudgen_frac

Programmable fractional-N baud tick generator; the second-generation UART timing source. From a single system clock it produces single-cycle enable pulses at BaudRate×OverSample, plus a bit-boundary tick and a mid-bit sample tick. Its integer+fractional divisor is runtime-loadable and its phase can be restarted, so one instance can drive a TX or RX channel at any baud without clock-domain crossings.

## Interface
- SystemClockFreq, 50_000_000, system clock in Hz
- BaudRate, 9600, reset baud rate
- OverSample, 16, os ticks per bit; even, ≥4
- IntWidth, 16, integer divisor width
- FracWidth, 8, fractional divisor width (units of 2^-FracWidth clocks)
- i_clk  in  1  system clock; all logic on the rising edge
- i_rst_n  in  1  reset, asynchronous and active-low
- i_en  in  1  1 = run; 0 = hold all state, no ticks
- i_sync  in  1  phase restart strobe (RX start-bit alignment)
- i_div_load  in  1  load strobe for i_div_int/i_div_frac
- i_div_int  in  IntWidth  clocks per os tick, integer part
- i_div_frac  in  FracWidth  clocks per os tick, fractional part
- o_os_tick  out  1  one-cycle pulse at the oversample rate
- o_bit_tick  out  1  one-cycle pulse, every OverSample-th os tick
- o_mid_tick  out  1  one-cycle pulse at the mid-bit os tick
- o_os_idx  out  $clog2(OverSample)  os-tick index within the bit
- o_cfg_err  out  1  sticky: last load was rejected

## Operation
- Divisor D = div_int + div_frac/2^FracWidth clocks per os tick.
- Reset values: div_int = SystemClockFreq/(BaudRate·OverSample); div_frac = floor(remainder·2^FracWidth/(BaudRate·OverSample)). With defaults: 325 and 133.
- Load: i_div_load with i_div_int ≥ 2 captures both fields and clears o_cfg_err. With i_div_int < 2 the load is ignored, the old divisor is kept, and o_cfg_err is set.
- Fractional accumulator acc (FracWidth bits, resets to 0). At each interval start: sum = acc + div_frac, where carry is the bit above FracWidth. The interval length is P = div_int + carry, and acc ← sum mod 2^FracWidth.
- Interval start events: end of the previous interval, an i_sync, or leaving reset.
- A load applies from the next interval start, because P is latched; the current interval completes at its old length.
- Counter cnt is IntWidth+1 bits wide, covering P up to 2^IntWidth. It advances on each edge with i_en=1. At cnt = P−1 the interval ends: cnt←0, o_os_tick=1, o_os_idx increments and wraps at OverSample−1.
- o_bit_tick is asserted with the os tick where o_os_idx wraps to 0.
- o_mid_tick is asserted with the os tick where o_os_idx becomes OverSample/2.
- i_sync on an enabled or disabled edge sets cnt←0, acc←0, o_os_idx←0, latches a fresh P, and suppresses any tick due on that edge.
- Priority: i_sync beats the interval end. Simultaneous i_sync and a valid i_div_load uses the new divisor for the restarted interval.
- i_en=0: cnt, acc and o_os_idx hold, and all tick outputs are 0. Loads are still accepted.

## Timing
- All outputs are registered. Reset values: o_os_tick=0, o_bit_tick=0, o_mid_tick=0, o_os_idx=0, o_cfg_err=0.
- Async reset mid-operation clears all outputs and state immediately and restores the default divisor.
- Tick timing: counting the first enabled edge after reset or i_sync as edge 1, o_os_tick is high for exactly the one cycle following edge P. Subsequent ticks are spaced by their interval lengths.
- Tick pulses are never on consecutive cycles, since P ≥ 2.
- Over 2^FracWidth consecutive intervals without sync or load, the total length is exactly 2^FracWidth·div_int + div_frac cycles.
- Load latency: a valid load updates o_cfg_err the cycle after the i_div_load edge. It affects P at the next interval start.

## Test plan
- Reset, i_en=1, defaults → 256 os ticks span exactly 83 333 cycles; o_bit_tick every 16 os ticks; o_cfg_err=0.
- Load int=4, frac=0 then i_sync → o_os_tick every 4 cycles; o_bit_tick every 64 cycles; o_mid_tick 32 cycles after each bit tick.
- Load int=4, frac=128, i_sync → interval lengths 4,5,4,5,…; acc returns to 0 every 2 intervals.
- int=4 running, i_sync asserted 2 cycles after a tick → no tick at the old due point; next tick 4 cycles after sync; o_os_idx=1 on it.
- Load int=1 → o_cfg_err=1 and tick spacing unchanged. Then load int=6 → o_cfg_err=0 and spacing 6 from the next interval. i_en=0 for 10 cycles mid-interval → no ticks; the interval resumes with its remaining count.
- Assert i_rst_n low mid-interval → all outputs 0 asynchronously; after release, default 325/133 timing resumes from idx 0.
